// File: rtl/score_pkg.sv
// score_pkg
//   Constants and types shared by the score display producer and the score
//   plotter. Glyph geometry fixes the bitmap layout: bit 30d+6r+c holds
//   digit d (0 = leftmost), row r (0 = top), column c (0 = leftmost).
package score_pkg;

  localparam int GLYPH_W    = 6;
  localparam int GLYPH_H    = 5;
  localparam int NUM_DIGITS = 3;
  localparam int BITMAP_W   = GLYPH_W * GLYPH_H * NUM_DIGITS;  // 90

  typedef logic [2:0] colour_t;

  localparam colour_t COLOUR_WHITE = 3'b111;
  localparam colour_t COLOUR_BLACK = 3'b000;

  // Raster position of the pixel currently presented. Field widths cover
  // r 0..4, c 0..5, d 0..2 and sub-pixel offsets 0..3 (SCALE up to 4).
  typedef struct packed {
    logic [2:0] r;
    logic [1:0] sy;
    logic [1:0] d;
    logic [2:0] c;
    logic [1:0] sx;
  } raster_pos_t;

  // Bitmap bit that drives glyph cell (d, r, c).
  function automatic logic [6:0] glyph_bit(input logic [1:0] d,
                                           input logic [2:0] r,
                                           input logic [2:0] c);
    glyph_bit = 7'(GLYPH_W * GLYPH_H) * {5'b0, d}
              + 7'(GLYPH_W) * {4'b0, r}
              + {4'b0, c};
  endfunction

endpackage

// File: rtl/score_raster_counter.sv
// score_raster_counter
//   Five nested raster counters that walk the score region one pixel per
//   enable. Nesting, outermost to innermost: r, sy, d, c, sx.
//
//   Ports
//     clk    system clock
//     rst    asynchronous active-high reset, all counters to 0
//     clear  synchronous clear of all counters (start of a new draw)
//     en     advance by one pixel (pixel accepted)
//     pos    current raster position
//     last   position is the final pixel of the region
module score_raster_counter
  import score_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  output raster_pos_t pos,
  output logic        last
);

  localparam logic [1:0] S_MAX = 2'(SCALE - 1);
  localparam logic [2:0] C_MAX = 3'(GLYPH_W - 1);
  localparam logic [1:0] D_MAX = 2'(NUM_DIGITS - 1);
  localparam logic [2:0] R_MAX = 3'(GLYPH_H - 1);

  logic sx_wrap;
  logic c_wrap;
  logic d_wrap;
  logic sy_wrap;
  logic r_wrap;

  assign sx_wrap = (pos.sx == S_MAX);
  assign c_wrap  = (pos.c  == C_MAX);
  assign d_wrap  = (pos.d  == D_MAX);
  assign sy_wrap = (pos.sy == S_MAX);
  assign r_wrap  = (pos.r  == R_MAX);

  assign last = sx_wrap && c_wrap && d_wrap && sy_wrap && r_wrap;

  // Each inner counter wrapping carries into the next outer one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (clear) begin
      pos <= '0;
    end else if (en) begin
      if (!sx_wrap) begin
        pos.sx <= pos.sx + 2'd1;
      end else begin
        pos.sx <= '0;
        if (!c_wrap) begin
          pos.c <= pos.c + 3'd1;
        end else begin
          pos.c <= '0;
          if (!d_wrap) begin
            pos.d <= pos.d + 2'd1;
          end else begin
            pos.d <= '0;
            if (!sy_wrap) begin
              pos.sy <= pos.sy + 2'd1;
            end else begin
              pos.sy <= '0;
              if (!r_wrap) begin
                pos.r <= pos.r + 3'd1;
              end else begin
                pos.r <= '0;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/score_plotter.sv
// score_plotter
//   Serial raster plotter for the three-digit score. On start it snapshots
//   the 90-bit glyph bitmap and writes the 18x5 cell region (each cell a
//   SCALE x SCALE block) to the VGA adapter, one pixel per accepted cycle.
//   Set bits are drawn in FG and clear bits in BG, so a redraw erases the
//   previous score.
//
//   Handshake: plot is the valid, plot_ready the ready. A pixel transfers on
//   every rising edge where plot = 1 and plot_ready = 1. While plot_ready is
//   low, x/y/colour/plot hold. plot never waits on plot_ready and no output
//   depends combinationally on plot_ready.
//
//   Ports
//     clk, reset   clock, asynchronous active-high reset
//     start        draw request, sampled only while idle
//     bitmap       glyph bits, bit 30d+6r+c
//     plot_ready   adapter accepts the current pixel
//     busy         draw in progress
//     done         one-cycle pulse after the last pixel is accepted
//     x, y, colour pixel presented to the adapter
//     plot         pixel valid
//     dbg_state    FSM state (0 = IDLE, 1 = DRAW)
module score_plotter
  import score_pkg::*;
#(
  parameter int      X0    = 8,
  parameter int      Y0    = 2,
  parameter int      SCALE = 1,
  parameter colour_t FG    = 3'b111,
  parameter colour_t BG    = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITMAP_W-1:0] bitmap,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                dbg_state
);

  if ((SCALE < 1) || (SCALE > 4)) begin : g_bad_scale
    $error("score_plotter: SCALE must be in 1..4");
  end

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DRAW = 1'b1;

  logic                state;
  logic [BITMAP_W-1:0] snapshot;
  logic                launch;
  logic                accept;
  logic                last;
  raster_pos_t         pos;
  logic [7:0]          x_calc;
  logic [6:0]          y_calc;
  logic [6:0]          bit_sel;

  assign launch = (state == ST_IDLE) && start;
  assign accept = (state == ST_DRAW) && plot_ready;

  score_raster_counter #(
    .SCALE (SCALE)
  ) u_counter (
    .clk   (clk),
    .rst   (reset),
    .clear (launch),
    .en    (accept),
    .pos   (pos),
    .last  (last)
  );

  // FSM, snapshot and done pulse. The snapshot is only loaded on launch so
  // a bitmap update mid-draw cannot tear the displayed score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      snapshot <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_DRAW;
            snapshot <= bitmap;
          end
        end
        ST_DRAW: begin
          if (accept && last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel coordinates. Only the low 8 (x) and 7 (y) bits of the sums reach
  // the ports and the region never exceeds the screen, so the sums are
  // formed directly at port width; modular arithmetic gives the same bits.
  assign x_calc = 8'(X0)
                + 8'(GLYPH_W * SCALE) * {6'b0, pos.d}
                + 8'(SCALE) * {5'b0, pos.c}
                + {6'b0, pos.sx};

  assign y_calc = 7'(Y0)
                + 7'(SCALE) * {4'b0, pos.r}
                + {5'b0, pos.sy};

  assign bit_sel = glyph_bit(pos.d, pos.r, pos.c);

  // Outputs decode registered state only. Outside a draw they sit at the
  // reset values so the adapter sees a quiet bus.
  assign busy      = (state == ST_DRAW);
  assign plot      = busy;
  assign dbg_state = state;
  assign x         = busy ? x_calc : 8'd0;
  assign y         = busy ? y_calc : 7'd0;
  assign colour    = (busy && snapshot[bit_sel]) ? FG : BG;

endmodule

// File: tb/tb_score_plotter.sv
module tb_score_plotter;

  localparam int X0 = 10;
  localparam int Y0 = 20;
  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [89:0] bitmap = '0;
  logic        plot_ready = 1'b1;
  logic        sel = 1'b0;  // 0: SCALE=1 instance, 1: SCALE=2 instance

  logic        a_busy, a_done, a_plot, a_dbg;
  logic [7:0]  a_x;
  logic [6:0]  a_y;
  logic [2:0]  a_colour;
  logic        b_busy, b_done, b_plot, b_dbg;
  logic [7:0]  b_x;
  logic [6:0]  b_y;
  logic [2:0]  b_colour;

  logic        o_busy, o_done, o_plot;
  logic [7:0]  o_x;
  logic [6:0]  o_y;
  logic [2:0]  o_colour;

  score_plotter #(.X0(X0), .Y0(Y0), .SCALE(1), .FG(FG), .BG(BG)) u_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .bitmap(bitmap),
    .plot_ready(plot_ready), .busy(a_busy), .done(a_done), .x(a_x),
    .y(a_y), .colour(a_colour), .plot(a_plot), .dbg_state(a_dbg)
  );

  score_plotter #(.X0(X0), .Y0(Y0), .SCALE(2), .FG(FG), .BG(BG)) u_b (
    .clk(clk), .reset(reset), .start(start & sel), .bitmap(bitmap),
    .plot_ready(plot_ready), .busy(b_busy), .done(b_done), .x(b_x),
    .y(b_y), .colour(b_colour), .plot(b_plot), .dbg_state(b_dbg)
  );

  always_comb begin
    o_busy   = sel ? b_busy   : a_busy;
    o_done   = sel ? b_done   : a_done;
    o_plot   = sel ? b_plot   : a_plot;
    o_x      = sel ? b_x      : a_x;
    o_y      = sel ? b_y      : a_y;
    o_colour = sel ? b_colour : a_colour;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  int r_pix, r_done, r_stall, r_fgcnt, r_fgidx;
  logic [14:0] fg_q[$];   // {x, y} of every FG pixel seen
  logic [14:0] exp_q[$];  // expected FG pixels

  // Reference raster: pixel k = ((((r*s+sy)*3+d)*6+c)*s+sx).
  function automatic logic [17:0] model_pix(input int k, input int s,
                                            input logic [89:0] bm);
    int sx, c, d, sy, r, t, px, py;
    logic [2:0] col;
    sx = k % s;  t = k / s;
    c  = t % 6;  t = t / 6;
    d  = t % 3;  t = t / 3;
    sy = t % s;  r = t / s;
    px = X0 + (6 * d + c) * s + sx;
    py = Y0 + r * s + sy;
    col = bm[30 * d + 6 * r + c] ? FG : BG;
    return {8'(px), 7'(py), col};
  endfunction

  // ---------------- driver ----------------
  // mode 0: ready always 1; mode 1: 3-cycle stall at pixel 5 then random;
  // mode 2: start re-pulse and bitmap change at pixel 30.
  task automatic draw(input logic [89:0] bm, input int mode, input int reset_at,
                      input bit skip_start, input bit chain,
                      input logic [89:0] next_bm);
    int n, s, hold;
    bit injected, aborted, stalled_prev;
    logic [17:0] exp_p, got_p, prev_p;
    s = sel ? 2 : 1;
    r_pix = 0; r_done = -1; r_stall = 0; r_fgcnt = 0; r_fgidx = -1;
    fg_q.delete();
    n = 0; hold = 0; injected = 0; aborted = 0; stalled_prev = 0; prev_p = '0;
    if (!skip_start) begin
      @(negedge clk);
      bitmap = bm;
      start = 1'b1;
    end
    while (n < 2000 && r_done < 0 && !aborted) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      plot_ready = 1'b1;
      if (mode == 1) begin
        if (r_pix == 5 && hold < 3) begin
          plot_ready = 1'b0;
          hold++;
        end else if (r_pix > 5) begin
          plot_ready = 1'($urandom_range(0, 1));
        end
      end
      if (mode == 2 && r_pix == 30 && !injected) begin
        start = 1'b1;
        bitmap = ~bm;
        injected = 1'b1;
      end
      if (reset_at >= 0 && r_pix == reset_at) begin
        reset = 1'b1;
        #1;
        checks++;
        if (o_plot !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
          failures++;
          $display("FAIL async_reset: plot=%b busy=%b done=%b required 0 0 0",
                   o_plot, o_busy, o_done);
        end
        aborted = 1'b1;
      end else if (o_done === 1'b1) begin
        r_done = n;
        if (chain) begin
          start = 1'b1;
          bitmap = next_bm;
        end
      end else begin
        got_p = {o_x, o_y, o_colour};
        checks++;
        if (o_plot !== 1'b1 || o_busy !== 1'b1) begin
          failures++;
          $display("FAIL plot_busy: cycle %0d plot=%b busy=%b required 1 1",
                   n, o_plot, o_busy);
        end
        if (stalled_prev) begin
          checks++;
          if (got_p !== prev_p) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d got %h required %h", n, got_p, prev_p);
          end
        end
        if (plot_ready) begin
          exp_p = model_pix(r_pix, s, bm);
          checks++;
          if (got_p !== exp_p) begin
            failures++;
            $display("FAIL pixel %0d: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                     r_pix, o_x, o_y, o_colour, exp_p[17:10], exp_p[9:3], exp_p[2:0]);
          end
          if (o_colour === FG) begin
            fg_q.push_back({o_x, o_y});
            r_fgcnt++;
            r_fgidx = r_pix;
          end
          r_pix++;
        end else begin
          r_stall++;
        end
        stalled_prev = !plot_ready;
        prev_p = got_p;
      end
    end
    plot_ready = 1'b1;
    if (r_done < 0 && !aborted) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done after %0d cycles, %0d pixels", n, r_pix);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic check_fg_list(input string name);
    checks++;
    if (fg_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s: %0d FG pixels, required %0d", name, fg_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (fg_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s[%0d]: got (%0d,%0d) required (%0d,%0d)", name, i,
                   fg_q[i][14:7], fg_q[i][6:0], exp_q[i][14:7], exp_q[i][6:0]);
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_plot !== 1'b0 ||
        a_x !== 8'd0 || a_y !== 7'd0 || a_colour !== BG) begin
      failures++;
      $display("FAIL reset_values: busy=%b done=%b plot=%b x=%0d y=%0d c=%0d required 0 0 0 0 0 0",
               a_busy, a_done, a_plot, a_x, a_y, a_colour);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_int("idle_after_reset", int'(a_busy), 0);
  endtask

  task automatic test_bit0;
    sel = 1'b0;
    draw(90'd1, 0, -1, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_q.push_back({8'd10, 7'd20});
    check_fg_list("bit0_fg");
    check_int("bit0_fg_idx", r_fgidx, 0);
    check_int("bit0_pixels", r_pix, 90);
    check_int("bit0_done_cycle", r_done, 91);
  endtask

  task automatic test_bit89;
    logic [89:0] bm;
    sel = 1'b0;
    bm = '0;
    bm[89] = 1'b1;
    draw(bm, 0, -1, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_q.push_back({8'd27, 7'd24});
    check_fg_list("bit89_fg");
    check_int("bit89_fg_idx", r_fgidx, 89);
    check_int("bit89_pixels", r_pix, 90);
  endtask

  task automatic test_scale2;
    sel = 1'b1;
    draw(90'd64, 0, -1, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_q.push_back({8'd10, 7'd22});
    exp_q.push_back({8'd11, 7'd22});
    exp_q.push_back({8'd10, 7'd23});
    exp_q.push_back({8'd11, 7'd23});
    check_fg_list("scale2_fg");
    check_int("scale2_pixels", r_pix, 360);
    check_int("scale2_done_cycle", r_done, 361);
    sel = 1'b0;
  endtask

  task automatic test_stall;
    logic [89:0] bm;
    sel = 1'b0;
    bm = 90'h2C5_F00D_1234_5678_9ABC_DE;
    draw(bm, 1, -1, 1'b0, 1'b0, '0);
    check_int("stall_pixels", r_pix, 90);
    checks++;
    if (r_stall < 3) begin
      failures++;
      $display("FAIL stall_count: got %0d required at least 3", r_stall);
    end
    check_int("stall_done_cycle", r_done, 91 + r_stall);
  endtask

  task automatic test_midstart;
    logic [89:0] bm;
    sel = 1'b0;
    bm = 90'h155_AAAA_5555_0F0F_F0F0_33;
    draw(bm, 2, -1, 1'b0, 1'b0, '0);
    check_int("midstart_pixels", r_pix, 90);
    check_int("midstart_done_cycle", r_done, 91);
  endtask

  task automatic test_back_to_back;
    logic [89:0] bm2;
    sel = 1'b0;
    bm2 = '0;
    bm2[35] = 1'b1;  // d=1 r=0 c=5 -> (21,20), pixel index 11
    draw(90'd1, 0, -1, 1'b0, 1'b1, bm2);
    check_int("b2b_first_done", r_done, 91);
    draw(bm2, 0, -1, 1'b1, 1'b0, '0);
    exp_q.delete();
    exp_q.push_back({8'd21, 7'd20});
    check_fg_list("b2b_second_fg");
    check_int("b2b_second_fg_idx", r_fgidx, 11);
    check_int("b2b_second_done", r_done, 91);
  endtask

  task automatic test_reset_mid;
    int seen_done;
    sel = 1'b0;
    draw(90'd1, 0, 40, 1'b0, 1'b0, '0);
    check_int("reset_mid_pixels", r_pix, 40);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_done === 1'b1 || a_busy === 1'b1) seen_done++;
    end
    check_int("reset_mid_no_done", seen_done, 0);
    draw(90'd1, 0, -1, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_q.push_back({8'd10, 7'd20});
    check_fg_list("after_reset_fg");
    check_int("after_reset_fg_idx", r_fgidx, 0);
    check_int("after_reset_done", r_done, 91);
  endtask

  initial begin
    test_reset();
    test_scale2();
    test_bit0();
    test_bit89();
    test_stall();
    test_midstart();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
